// File: rtl/wave_anim_ctrl.sv
// ---------------------------------------------------------------------------
// wave_anim_ctrl
// Frame-synchronous controller for the wave-warp pixel stage.
// Configuration commands arrive over a valid/ready handshake and land in
// shadow registers. They are committed at frame start only, so the warp
// datapath never sees a torn frame. The controller animates the warp phase
// offset across frames and drives enable/phase/amplitude into the datapath.
//
// Ports:
//   clk_in           system clock
//   rst_in           synchronous active-high reset
//   hcount_in        pixel column of incoming stream
//   vcount_in        pixel row of incoming stream
//   data_valid_in    incoming pixel valid
//   cmd_valid_in     command valid
//   cmd_op_in        opcode: 0 SET_STEP, 1 SET_AMP, 2 SET_DIV, 3 SET_MODE
//   cmd_arg_in       command argument
//   cmd_ready_out    command accepted when high together with cmd_valid_in
//   warp_en_out      warp stage enable (0 = bypass)
//   phase_out        phase offset added to row, 0..HEIGHT-1
//   amp_shift_out    polynomial shift amount for warp stage
//   frame_start_out  one-cycle pulse, one cycle after frame start sampled
//   state_out        FSM state: 0 IDLE, 1 RUN, 2 HOLD, 3 SINGLE
// ---------------------------------------------------------------------------
module wave_anim_ctrl #(
    parameter int HEIGHT      = 320,
    parameter int DEFAULT_AMP = 4,
    parameter int DIV_W       = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        data_valid_in,
    input  logic        cmd_valid_in,
    input  logic [1:0]  cmd_op_in,
    input  logic [8:0]  cmd_arg_in,
    output logic        cmd_ready_out,
    output logic        warp_en_out,
    output logic [8:0]  phase_out,
    output logic [2:0]  amp_shift_out,
    output logic        frame_start_out,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HOLD   = 2'd2,
        ST_SINGLE = 2'd3
    } state_t;

    localparam logic [1:0]       OP_SET_STEP = 2'd0;
    localparam logic [1:0]       OP_SET_AMP  = 2'd1;
    localparam logic [1:0]       OP_SET_DIV  = 2'd2;
    localparam logic [1:0]       OP_SET_MODE = 2'd3;
    localparam logic [8:0]       STEP_MAX    = 9'(HEIGHT - 1);
    localparam logic [9:0]       HEIGHT_W    = 10'(HEIGHT);
    localparam logic [2:0]       AMP_RST     = 3'(DEFAULT_AMP);
    localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO    = DIV_W'(0);

    // Registers
    state_t           r_state;
    logic             r_fs_cond_prev;
    logic [8:0]       r_phase;
    logic [DIV_W-1:0] r_cnt;
    logic             r_warp_en;
    logic             r_frame_start;
    logic [2:0]       r_act_amp;
    logic [8:0]       r_sh_step;
    logic [2:0]       r_sh_amp;
    logic [DIV_W-1:0] r_sh_div;
    logic [1:0]       r_sh_mode;

    // Combinational nets
    logic             w_fs_cond;
    logic             w_fs;
    logic             w_cmd_acc;
    logic [9:0]       w_sum;
    logic [8:0]       w_phase_adv;
    logic [DIV_W:0]   w_cnt_inc;
    logic [DIV_W-1:0] w_div_arg;
    state_t           w_state_nxt;
    logic [8:0]       w_phase_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic             w_warp_nxt;
    logic             w_single_done;

    // Frame start is edge-qualified so a run of (0,0) valid samples counts once.
    assign w_fs_cond = data_valid_in && (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign w_fs      = w_fs_cond && !r_fs_cond_prev;

    // The commit cycle refuses commands so shadow writes never race the commit.
    assign cmd_ready_out = !w_fs;
    assign w_cmd_acc     = cmd_valid_in && !w_fs;

    // Phase advance uses the shadow step, which is the value committed this edge.
    assign w_sum       = {1'b0, r_phase} + {1'b0, r_sh_step};
    assign w_phase_adv = (w_sum >= HEIGHT_W) ? 9'(w_sum - HEIGHT_W) : w_sum[8:0];
    assign w_cnt_inc   = {1'b0, r_cnt} + {DIV_ZERO, 1'b1};
    assign w_div_arg   = cmd_arg_in[DIV_W-1:0];

    // Next-state logic: the committed mode is applied only at frame start.
    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_cnt_nxt     = r_cnt;
        w_warp_nxt    = r_warp_en;
        w_single_done = 1'b0;
        if (w_fs) begin
            case (r_sh_mode)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                    w_phase_nxt = 9'd0;
                    w_cnt_nxt   = DIV_ZERO;
                    w_warp_nxt  = 1'b0;
                end
                ST_RUN: begin
                    w_state_nxt = ST_RUN;
                    w_warp_nxt  = 1'b1;
                    if (w_cnt_inc >= {1'b0, r_sh_div}) begin
                        w_phase_nxt = w_phase_adv;
                        w_cnt_nxt   = DIV_ZERO;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc[DIV_W-1:0];
                    end
                end
                ST_HOLD: begin
                    w_state_nxt = ST_HOLD;
                    w_warp_nxt  = 1'b1;
                end
                ST_SINGLE: begin
                    // One-shot step, then settle in HOLD for following frames.
                    w_state_nxt   = ST_HOLD;
                    w_phase_nxt   = w_phase_adv;
                    w_warp_nxt    = 1'b1;
                    w_single_done = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_phase_nxt = 9'd0;
                    w_cnt_nxt   = DIV_ZERO;
                    w_warp_nxt  = 1'b0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State register and frame-synchronous output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state        <= ST_IDLE;
            r_fs_cond_prev <= 1'b0;
            r_phase        <= 9'd0;
            r_cnt          <= DIV_ZERO;
            r_warp_en      <= 1'b0;
            r_frame_start  <= 1'b0;
            r_act_amp      <= AMP_RST;
        end else begin
            r_state        <= w_state_nxt;
            r_fs_cond_prev <= w_fs_cond;
            r_phase        <= w_phase_nxt;
            r_cnt          <= w_cnt_nxt;
            r_warp_en      <= w_warp_nxt;
            r_frame_start  <= w_fs;
            if (w_fs) begin
                r_act_amp <= r_sh_amp;
            end else begin
                r_act_amp <= r_act_amp;
            end
        end
    end

    // Shadow registers: accepted commands, plus SINGLE rewriting itself to HOLD.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sh_step <= 9'd1;
            r_sh_amp  <= AMP_RST;
            r_sh_div  <= DIV_ONE;
            r_sh_mode <= ST_IDLE;
        end else if (w_single_done) begin
            r_sh_mode <= ST_HOLD;
        end else if (w_cmd_acc) begin
            case (cmd_op_in)
                OP_SET_STEP: r_sh_step <= (cmd_arg_in > STEP_MAX) ? STEP_MAX : cmd_arg_in;
                OP_SET_AMP:  r_sh_amp  <= cmd_arg_in[2:0];
                OP_SET_DIV:  r_sh_div  <= (w_div_arg == DIV_ZERO) ? DIV_ONE : w_div_arg;
                OP_SET_MODE: r_sh_mode <= cmd_arg_in[1:0];
                default:     r_sh_mode <= r_sh_mode;
            endcase
        end else begin
            r_sh_mode <= r_sh_mode;
        end
    end

    assign warp_en_out     = r_warp_en;
    assign phase_out       = r_phase;
    assign amp_shift_out   = r_act_amp;
    assign frame_start_out = r_frame_start;
    assign state_out       = r_state;

endmodule

// File: tb/tb_wave_anim_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wave_anim_ctrl
// Self-checking bench for wave_anim_ctrl: a frame-level vector table with
// hand-derived expectations, hand-written corner sequences, and a randomized
// run compared every cycle against a behavioural frame model.
// ---------------------------------------------------------------------------
module tb_wave_anim_ctrl;

    localparam int H = 320;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        data_valid_in;
    logic        cmd_valid_in;
    logic [1:0]  cmd_op_in;
    logic [8:0]  cmd_arg_in;
    logic        cmd_ready_out;
    logic        warp_en_out;
    logic [8:0]  phase_out;
    logic [2:0]  amp_shift_out;
    logic        frame_start_out;
    logic [1:0]  state_out;

    always #5 clk_in = ~clk_in;

    wave_anim_ctrl #(.HEIGHT(320), .DEFAULT_AMP(4), .DIV_W(4)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .hcount_in       (hcount_in),
        .vcount_in       (vcount_in),
        .data_valid_in   (data_valid_in),
        .cmd_valid_in    (cmd_valid_in),
        .cmd_op_in       (cmd_op_in),
        .cmd_arg_in      (cmd_arg_in),
        .cmd_ready_out   (cmd_ready_out),
        .warp_en_out     (warp_en_out),
        .phase_out       (phase_out),
        .amp_shift_out   (amp_shift_out),
        .frame_start_out (frame_start_out),
        .state_out       (state_out)
    );

    int checks = 0;
    int errors = 0;
    int last_rdy;

    // Behavioural model: frame-level view of what the controller must do.
    int m_state, m_phase, m_cnt, m_amp, m_warp, m_fsp, m_prev;
    int sh_step, sh_amp, sh_div, sh_mode;

    typedef struct {
        bit has_cmd;
        int op;
        int arg;
        bit do_frame;
        int e_phase;
        int e_state;
        int e_warp;
        int e_amp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_phase = 0; m_cnt = 0; m_amp = 4; m_warp = 0;
        m_fsp = 0; m_prev = 0;
        sh_step = 1; sh_amp = 4; sh_div = 1; sh_mode = 0;
    endtask

    // One clock cycle: drive, check ready mid-cycle, clock, update model, compare.
    task automatic cyc(input bit rst, input bit dv, input int h, input int v,
                       input bit cv, input int op, input int arg);
        bit fsc, fs;
        rst_in        = rst;
        data_valid_in = dv;
        hcount_in     = h[10:0];
        vcount_in     = v[9:0];
        cmd_valid_in  = cv;
        cmd_op_in     = op[1:0];
        cmd_arg_in    = arg[8:0];
        fsc = dv && (h == 0) && (v == 0);
        fs  = fsc && (m_prev == 0);
        @(negedge clk_in);
        last_rdy = int'(cmd_ready_out);
        chk("cmd_ready", last_rdy, fs ? 0 : 1);
        @(posedge clk_in);
        if (rst) begin
            model_reset();
        end else begin
            if (fs) begin
                m_amp = sh_amp;
                case (sh_mode)
                    0: begin m_state = 0; m_phase = 0; m_cnt = 0; end
                    1: begin
                        m_state = 1;
                        if (m_cnt + 1 >= sh_div) begin
                            m_phase = (m_phase + sh_step) % H;
                            m_cnt = 0;
                        end else begin
                            m_cnt = m_cnt + 1;
                        end
                    end
                    2: m_state = 2;
                    default: begin
                        m_phase = (m_phase + sh_step) % H;
                        m_state = 2;
                        sh_mode = 2;
                    end
                endcase
                m_warp = (m_state != 0) ? 1 : 0;
            end
            if (cv && !fs) begin
                case (op)
                    0: sh_step = (arg > H - 1) ? H - 1 : arg;
                    1: sh_amp  = arg % 8;
                    2: sh_div  = ((arg % 16) == 0) ? 1 : arg % 16;
                    default: sh_mode = arg % 4;
                endcase
            end
            m_prev = fsc ? 1 : 0;
            m_fsp  = fs ? 1 : 0;
        end
        #1;
        chk("state", int'(state_out), m_state);
        chk("phase", int'(phase_out), m_phase);
        chk("amp", int'(amp_shift_out), m_amp);
        chk("warp_en", int'(warp_en_out), m_warp);
        chk("frame_start", int'(frame_start_out), m_fsp);
    endtask

    task automatic idle_cyc(input int h);
        cyc(1'b0, 1'b1, h, 3, 1'b0, 0, 0);
    endtask

    task automatic cmd(input int op, input int arg);
        cyc(1'b0, 1'b1, 5, 3, 1'b1, op, arg);
    endtask

    // A frame: start-of-frame sample followed by ordinary pixels.
    task automatic frame();
        cyc(1'b0, 1'b1, 0, 0, 1'b0, 0, 0);
        chk("fs_pulse_hi", int'(frame_start_out), 1);
        for (int k = 1; k <= 4; k++) begin
            idle_cyc(k);
        end
        chk("fs_pulse_lo", int'(frame_start_out), 0);
    endtask

    task automatic add(input bit hc, input int op, input int arg, input bit df,
                       input int ep, input int es, input int ew, input int ea);
        vec_t r;
        r.has_cmd = hc; r.op = op; r.arg = arg; r.do_frame = df;
        r.e_phase = ep; r.e_state = es; r.e_warp = ew; r.e_amp = ea;
        tbl.push_back(r);
    endtask

    initial begin
        // Frame-level vectors: {cmd?, op, arg, frame?, phase, state, warp, amp}
        add(0, 0, 0,   1,   0, 0, 0, 4);
        add(0, 0, 0,   1,   0, 0, 0, 4);
        add(0, 0, 0,   1,   0, 0, 0, 4);
        add(1, 0, 100, 0,   0, 0, 0, 4);
        add(1, 3, 1,   1, 100, 1, 1, 4);
        add(0, 0, 0,   1, 200, 1, 1, 4);
        add(0, 0, 0,   1, 300, 1, 1, 4);
        add(0, 0, 0,   1,  80, 1, 1, 4);
        add(0, 0, 0,   1, 180, 1, 1, 4);
        add(1, 0, 500, 0,   0, 0, 0, 4);
        add(1, 3, 0,   1,   0, 0, 0, 4);
        add(1, 3, 1,   1, 319, 1, 1, 4);
        add(0, 0, 0,   1, 318, 1, 1, 4);
        add(1, 3, 0,   1,   0, 0, 0, 4);
        add(1, 0, 10,  0,   0, 0, 0, 4);
        add(1, 2, 3,   0,   0, 0, 0, 4);
        add(1, 3, 1,   1,   0, 1, 1, 4);
        add(0, 0, 0,   1,   0, 1, 1, 4);
        add(0, 0, 0,   1,  10, 1, 1, 4);
        add(0, 0, 0,   1,  10, 1, 1, 4);
        add(0, 0, 0,   1,  10, 1, 1, 4);
        add(0, 0, 0,   1,  20, 1, 1, 4);
        add(0, 0, 0,   1,  20, 1, 1, 4);
        add(0, 0, 0,   1,  20, 1, 1, 4);
        add(0, 0, 0,   1,  30, 1, 1, 4);
        add(1, 2, 0,   1,  40, 1, 1, 4);
        add(0, 0, 0,   1,  50, 1, 1, 4);
        add(1, 3, 2,   1,  50, 2, 1, 4);
        add(1, 0, 7,   1,  50, 2, 1, 4);
        add(1, 3, 3,   1,  57, 2, 1, 4);
        add(0, 0, 0,   1,  57, 2, 1, 4);
        add(0, 0, 0,   1,  57, 2, 1, 4);
        add(0, 0, 0,   1,  57, 2, 1, 4);
        add(1, 1, 509, 1,  57, 2, 1, 5);

        model_reset();
        cyc(1'b1, 1'b0, 7, 7, 1'b0, 0, 0);
        cyc(1'b1, 1'b0, 7, 7, 1'b0, 0, 0);
        chk("rst_state", int'(state_out), 0);
        chk("rst_amp", int'(amp_shift_out), 4);
        idle_cyc(9);

        foreach (tbl[i]) begin
            if (tbl[i].has_cmd) cmd(tbl[i].op, tbl[i].arg);
            if (tbl[i].do_frame) begin
                frame();
                chk($sformatf("vec%0d_phase", i), int'(phase_out), tbl[i].e_phase);
                chk($sformatf("vec%0d_state", i), int'(state_out), tbl[i].e_state);
                chk($sformatf("vec%0d_warp", i), int'(warp_en_out), tbl[i].e_warp);
                chk($sformatf("vec%0d_amp", i), int'(amp_shift_out), tbl[i].e_amp);
            end
        end

        // Command presented in the commit cycle is held and lands one frame later.
        idle_cyc(3);
        cyc(1'b0, 1'b1, 0, 0, 1'b1, 1, 2);
        chk("ready_in_fs", last_rdy, 0);
        chk("amp_in_fs", int'(amp_shift_out), 5);
        cyc(1'b0, 1'b1, 1, 0, 1'b1, 1, 2);
        chk("ready_after_fs", last_rdy, 1);
        chk("amp_not_yet", int'(amp_shift_out), 5);
        for (int k = 2; k <= 4; k++) idle_cyc(k);
        chk("amp_still_old", int'(amp_shift_out), 5);
        frame();
        chk("amp_next_frame", int'(amp_shift_out), 2);

        // Consecutive start samples count as a single frame.
        cmd(3, 1);
        cyc(1'b0, 1'b1, 0, 0, 1'b0, 0, 0);
        chk("spur_phase1", int'(phase_out), 64);
        chk("spur_pulse1", int'(frame_start_out), 1);
        cyc(1'b0, 1'b1, 0, 0, 1'b0, 0, 0);
        chk("spur_phase2", int'(phase_out), 64);
        chk("spur_pulse2", int'(frame_start_out), 0);
        cyc(1'b0, 1'b1, 0, 0, 1'b0, 0, 0);
        chk("spur_phase3", int'(phase_out), 64);
        idle_cyc(1);
        frame();
        chk("spur_next_phase", int'(phase_out), 71);

        // Reset during a start-of-frame cycle with a command pending wins.
        idle_cyc(2);
        cyc(1'b1, 1'b1, 0, 0, 1'b1, 3, 3);
        chk("midrst_state", int'(state_out), 0);
        chk("midrst_phase", int'(phase_out), 0);
        chk("midrst_amp", int'(amp_shift_out), 4);
        chk("midrst_warp", int'(warp_en_out), 0);
        chk("midrst_pulse", int'(frame_start_out), 0);
        idle_cyc(1);
        frame();
        chk("post_rst_state", int'(state_out), 0);
        chk("post_rst_phase", int'(phase_out), 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            bit r_rst, r_dv, r_cv;
            int r_h, r_v, r_op, r_arg;
            r_rst = ($urandom_range(0, 399) == 0);
            r_dv  = ($urandom_range(0, 3) != 0);
            r_h   = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 1279));
            r_v   = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 719));
            r_cv  = ($urandom_range(0, 3) == 0);
            r_op  = int'($urandom_range(0, 3));
            r_arg = int'($urandom_range(0, 511));
            cyc(r_rst, r_dv, r_h, r_v, r_cv, r_op, r_arg);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
